// File: rtl/shifter_pkg.sv
// Shared types and defaults for the shifter family (left barrel shifter and
// the multicycle right shifter).
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Operand width used by default across the shifter blocks and their benches.
    localparam int SHIFT_DEFAULT_W = 8;

endpackage

// File: rtl/multicycle_right_shifter.sv
// Divides an N-bit operand by 2**base2exp, one bit per clock, with a
// start/busy/done handshake and a sticky bit for lost precision.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; data_out holds the last result
//   SHIFT | shifting one bit per cycle, count_q holds the shifts left
//   DONE  | one-cycle done pulse; start here is accepted back-to-back
module multicycle_right_shifter
    import shifter_pkg::*;
#(
    parameter int N    = SHIFT_DEFAULT_W,
    parameter int EXPW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            start,
    input  logic [N-1:0]    data_in,
    input  logic [EXPW-1:0] base2exp,
    input  logic            arith,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    data_out,
    output logic            sticky
);

    shift_state_t    state_q, state_d;
    logic [N-1:0]    work_q, work_d;
    logic [EXPW-1:0] count_q, count_d;
    logic            arith_q, arith_d;
    logic            sticky_q, sticky_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            arith_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            arith_q  <= arith_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        arith_d  = arith_q;
        sticky_d = sticky_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d   = data_in;
                    count_d  = base2exp;
                    arith_d  = arith;
                    sticky_d = 1'b0;
                    state_d  = (base2exp == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d   = {(arith_q & work_q[N-1]), work_q[N-1:1]};
                sticky_d = sticky_q | work_q[0];
                count_d  = count_q - EXPW'(1);
                // The edge that performs the last shift also enters DONE.
                if (count_q == EXPW'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign data_out = work_q;
    assign sticky   = sticky_q;

endmodule

// File: tb/tb_multicycle_right_shifter.sv
// Directed bench for multicycle_right_shifter: hand-computed results,
// latency, handshake, back-to-back and abort-by-reset cases.
module tb_multicycle_right_shifter;

    localparam int N    = 8;
    localparam int EXPW = 3;

    logic            clk;
    logic            rstN;
    logic            start;
    logic [N-1:0]    data_in;
    logic [EXPW-1:0] base2exp;
    logic            arith;
    logic            busy;
    logic            done;
    logic [N-1:0]    data_out;
    logic            sticky;

    int checks = 0;
    int errors = 0;

    multicycle_right_shifter #(.N(N)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .start    (start),
        .data_in  (data_in),
        .base2exp (base2exp),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request so it is sampled on the next rising edge, then drop it
    // and scramble the inputs (they may change freely after acceptance).
    task automatic issue(input logic [N-1:0] d, input logic [EXPW-1:0] e, input logic a);
        @(negedge clk);
        start    = 1'b1;
        data_in  = d;
        base2exp = e;
        arith    = a;
        @(posedge clk);
        #1;
        start    = 1'b0;
        data_in  = ~d;
        base2exp = ~e;
        arith    = ~a;
    endtask

    // Called #1 after the accepting edge; returns cycles to done (1 = first
    // cycle after the accepting edge), busy cycles seen and busy/done overlap.
    task automatic wait_done(output int lat, output int busy_cnt, output logic overlap);
        lat      = 1;
        busy_cnt = 0;
        overlap  = 1'b0;
        while (!done && lat <= N + 4) begin
            if (busy) busy_cnt++;
            if (busy && done) overlap = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] d, input logic [EXPW-1:0] e,
                          input logic a, input logic [N-1:0] exp_out, input logic exp_st);
        int   lat;
        int   bcnt;
        logic ovl;
        issue(d, e, a);
        wait_done(lat, bcnt, ovl);
        check({tag, " done"},     32'(done), 32'd1);
        check({tag, " latency"},  32'(lat), 32'(e) + 32'd1);
        check({tag, " busy_cyc"}, 32'(bcnt), 32'(e));
        check({tag, " overlap"},  32'(ovl), 32'd0);
        check({tag, " data"},     32'(data_out), 32'(exp_out));
        check({tag, " sticky"},   32'(sticky), 32'(exp_st));
        @(posedge clk);
        #1;
        check({tag, " pulse1"},   32'(done), 32'd0);
        check({tag, " idle_bsy"}, 32'(busy), 32'd0);
        check({tag, " hold"},     32'(data_out), 32'(exp_out));
    endtask

    initial begin
        int   lat;
        int   bcnt;
        logic ovl;
        rstN     = 1'b0;
        start    = 1'b0;
        data_in  = '0;
        base2exp = '0;
        arith    = 1'b0;
        #1;
        check("rst busy",   32'(busy), 32'd0);
        check("rst done",   32'(done), 32'd0);
        check("rst data",   32'(data_out), 32'd0);
        check("rst sticky", 32'(sticky), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        run_op("a0_e2_log", 8'hA0, 3'd2, 1'b0, 8'h28, 1'b0);
        run_op("85_e3_ari", 8'h85, 3'd3, 1'b1, 8'hF0, 1'b1);
        run_op("5a_e0",     8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0);
        run_op("81_e7_log", 8'h81, 3'd7, 1'b0, 8'h01, 1'b1);
        run_op("81_e7_ari", 8'h81, 3'd7, 1'b1, 8'hFF, 1'b1);
        run_op("ff_e5_ari", 8'hFF, 3'd5, 1'b1, 8'hFF, 1'b1);

        // Ignored mid-shift start, then back-to-back start in the done cycle.
        issue(8'hF0, 3'd4, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        data_in  = 8'h0F;
        base2exp = 3'd1;
        @(negedge clk);
        start    = 1'b0;
        @(posedge clk);
        #1;
        lat = 3;
        while (!done && lat <= N + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first lat",  32'(lat), 32'd5);
        check("b2b first data", 32'(data_out), 32'h0F);
        check("b2b first stk",  32'(sticky), 32'd0);
        start    = 1'b1;
        data_in  = 8'h40;
        base2exp = 3'd2;
        arith    = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 8'hFF;
        wait_done(lat, bcnt, ovl);
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second lat",  32'(lat), 32'd3);
        check("b2b second data", 32'(data_out), 32'h10);
        check("b2b second stk",  32'(sticky), 32'd0);

        // Abort mid-shift by asynchronous reset.
        repeat (2) @(posedge clk);
        issue(8'hC3, 3'd6, 1'b0);
        @(posedge clk);
        #1;
        check("abort pre busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        #1;
        check("abort busy",   32'(busy), 32'd0);
        check("abort done",   32'(done), 32'd0);
        check("abort data",   32'(data_out), 32'd0);
        check("abort sticky", 32'(sticky), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        bcnt = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) bcnt++;
        end
        check("abort no done", 32'(bcnt), 32'd0);
        run_op("post_rst", 8'h96, 3'd1, 1'b1, 8'hCB, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
